// File: rtl/cdc_count_accum.sv
// ============================================================================
// Module      : cdc_count_accum
// Description : Accumulates increments of a synchronised wrapping count, with
//               a saturating total and a ready/valid snapshot port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_count_accum #(
    parameter int SRC_W = 2,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SRC_W-1:0] count_i,
    input  logic             clr,
    input  logic             snap_req,
    input  logic             snap_ready,
    output logic [ACC_W-1:0] acc_o,
    output logic             sat_o,
    output logic [ACC_W-1:0] snap_data,
    output logic             snap_valid,
    output logic             snap_ovr
);

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state;
    logic [SRC_W-1:0] prev;
    logic [SRC_W-1:0] delta;
    logic [ACC_W:0]   sum;
    logic             capture;

    // Modular subtraction makes a wrap from all-ones to zero a step of one.
    assign delta   = count_i - prev;
    assign sum     = {1'b0, acc_o} + {{(ACC_W + 1 - SRC_W){1'b0}}, delta};
    assign capture = snap_req && (!snap_valid || snap_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PRIME;
            prev       <= '0;
            acc_o      <= '0;
            sat_o      <= 1'b0;
            snap_data  <= '0;
            snap_valid <= 1'b0;
            snap_ovr   <= 1'b0;
        end else begin
            state <= RUN;
            prev  <= count_i;

            if (clr) begin
                acc_o <= '0;
                sat_o <= 1'b0;
            end else if (state == RUN) begin
                if (sum[ACC_W]) begin
                    acc_o <= '1;
                    sat_o <= 1'b1;
                end else begin
                    acc_o <= sum[ACC_W-1:0];
                end
            end

            // Snapshot sees the total from before this edge's update or clear.
            if (capture) begin
                snap_data  <= acc_o;
                snap_valid <= 1'b1;
            end else if (snap_ready) begin
                snap_valid <= 1'b0;
            end

            if (snap_req && !capture) begin
                snap_ovr <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cdc_count_accum.sv
// ============================================================================
// Module      : tb_cdc_count_accum
// Description : Randomised bench for cdc_count_accum with a behavioural model,
//               run on a 16-bit and a 4-bit accumulator sharing one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdc_count_accum;

    logic        clk;
    logic        rst;
    logic [1:0]  count;
    logic        clr;
    logic        snap_req;
    logic        snap_ready;

    logic [15:0] acc_a, sd_a;
    logic        sat_a, sv_a, so_a;
    logic [3:0]  acc_b, sd_b;
    logic        sat_b, sv_b, so_b;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: index 0 is the 16-bit instance, index 1 the 4-bit one.
    longint m_acc [2];
    longint m_sd  [2];
    bit     m_sat [2];
    bit     m_valid;
    bit     m_ovr;
    bit     m_primed;
    int     m_prev;

    cdc_count_accum #(.SRC_W(2), .ACC_W(16)) dut_a (
        .clk(clk), .rst(rst), .count_i(count), .clr(clr),
        .snap_req(snap_req), .snap_ready(snap_ready),
        .acc_o(acc_a), .sat_o(sat_a), .snap_data(sd_a),
        .snap_valid(sv_a), .snap_ovr(so_a)
    );

    cdc_count_accum #(.SRC_W(2), .ACC_W(4)) dut_b (
        .clk(clk), .rst(rst), .count_i(count), .clr(clr),
        .snap_req(snap_req), .snap_ready(snap_ready),
        .acc_o(acc_b), .sat_o(sat_b), .snap_data(sd_b),
        .snap_valid(sv_b), .snap_ovr(so_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint maxv(input int i);
        return (i == 0) ? 64'd65535 : 64'd15;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("acc_a",   longint'(acc_a), m_acc[0]);
        chk("sat_a",   longint'(sat_a), longint'(m_sat[0]));
        chk("sdata_a", longint'(sd_a),  m_sd[0]);
        chk("svalid_a", longint'(sv_a), longint'(m_valid));
        chk("sovr_a",  longint'(so_a),  longint'(m_ovr));
        chk("acc_b",   longint'(acc_b), m_acc[1]);
        chk("sat_b",   longint'(sat_b), longint'(m_sat[1]));
        chk("sdata_b", longint'(sd_b),  m_sd[1]);
        chk("svalid_b", longint'(sv_b), longint'(m_valid));
        chk("sovr_b",  longint'(so_b),  longint'(m_ovr));
    endtask

    // Apply one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input bit r, input int cnt, input bit c, input bit q, input bit y);
        bit cap;
        int d;
        @(negedge clk);
        rst        = r;
        count      = cnt[1:0];
        clr        = c;
        snap_req   = q;
        snap_ready = y;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                m_acc[i] = 0;
                m_sd[i]  = 0;
                m_sat[i] = 1'b0;
            end
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
            m_primed = 1'b0;
            m_prev   = 0;
        end else begin
            cap = q && (!m_valid || y);
            d   = (cnt - m_prev + 4) % 4;
            for (int i = 0; i < 2; i++) begin
                if (cap) m_sd[i] = m_acc[i];
                if (c) begin
                    m_acc[i] = 0;
                    m_sat[i] = 1'b0;
                end else if (m_primed) begin
                    if (m_acc[i] + d > maxv(i)) begin
                        m_acc[i] = maxv(i);
                        m_sat[i] = 1'b1;
                    end else begin
                        m_acc[i] = m_acc[i] + d;
                    end
                end
            end
            if (cap)    m_valid = 1'b1;
            else if (y) m_valid = 1'b0;
            if (q && !cap) m_ovr = 1'b1;
            m_prev   = cnt;
            m_primed = 1'b1;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b1; count = 2'd2; clr = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
        m_valid = 1'b0; m_ovr = 1'b0; m_primed = 1'b0; m_prev = 0;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_sd[i] = 0; m_sat[i] = 1'b0;
        end

        // Reset state and priming with count held at 2.
        step(1, 2, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        chk("reset_acc", longint'(acc_a), 0);
        chk("reset_valid", longint'(sv_a), 0);
        step(0, 2, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        chk("prime_acc", longint'(acc_a), 0);

        // Steps 2->3->0->1 then a jump 1->0 (delta 3).
        step(0, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("wrap_acc", longint'(acc_a), 3);
        step(0, 0, 0, 0, 0);
        chk("jump_acc", longint'(acc_a), 6);

        // Drive the 4-bit instance to 14, then +3 saturates it.
        step(0, 3, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        step(0, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pre_sat_b", longint'(acc_b), 14);
        step(0, 3, 0, 0, 0);
        chk("sat_acc_b", longint'(acc_b), 15);
        chk("sat_flag_b", longint'(sat_b), 1);
        chk("nosat_acc_a", longint'(acc_a), 17);

        // Clear with a simultaneous +2 step, then +1.
        step(0, 1, 1, 0, 0);
        chk("clr_acc_b", longint'(acc_b), 0);
        chk("clr_sat_b", longint'(sat_b), 0);
        step(0, 2, 0, 0, 0);
        chk("post_clr_acc", longint'(acc_a), 1);

        // Build acc to 9, then snapshot together with clear.
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        chk("pre_snap_acc", longint'(acc_a), 9);
        step(0, 2, 1, 1, 0);
        chk("snapclr_data", longint'(sd_a), 9);
        chk("snapclr_valid", longint'(sv_a), 1);
        chk("snapclr_acc", longint'(acc_a), 0);

        // Request while stalled is dropped and flagged.
        step(0, 3, 0, 1, 0);
        chk("ovr_data", longint'(sd_a), 9);
        chk("ovr_flag", longint'(so_a), 1);

        // Back-to-back capture while the consumer accepts.
        step(0, 3, 0, 1, 1);
        chk("b2b_valid", longint'(sv_a), 1);
        chk("b2b_data", longint'(sd_a), 1);

        // Mid-operation reset; the first change afterwards only primes.
        step(1, 3, 1, 1, 1);
        chk("rst_valid", longint'(sv_a), 0);
        chk("rst_ovr", longint'(so_a), 0);
        chk("rst_data", longint'(sd_a), 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("rst_prime_acc", longint'(acc_a), 0);
        step(0, 2, 0, 0, 0);
        chk("rst_step_acc", longint'(acc_a), 1);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cdc_count_accum.md
CDC_COUNT_ACCUM -- requirements
Module: cdc_count_accum

Interface
REQ-001 The block SHALL have parameter SRC_W, default 2: width of the Gray-synchronised binary count input.
REQ-002 The block SHALL have parameter ACC_W, default 16: accumulator width, legal range SRC_W+1..32.
REQ-003 The block SHALL have port clk, input, 1: destination-domain clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port count_i, input, SRC_W: binary count already synchronised into the clk domain, wrapping modulo 2^SRC_W.
REQ-006 The block SHALL have port clr, input, 1: single-cycle request to clear the accumulator and the sat_o flag.
REQ-007 The block SHALL have port snap_req, input, 1: single-cycle request to capture acc_o.
REQ-008 The block SHALL have port snap_ready, input, 1: consumer is ready to accept snap_data.
REQ-009 The block SHALL have port acc_o, output, ACC_W: running total of source-domain increments.
REQ-010 The block SHALL have port sat_o, output, 1: sticky flag, set when the accumulator saturated.
REQ-011 The block SHALL have port snap_data, output, ACC_W: captured accumulator value.
REQ-012 The block SHALL have port snap_valid, output, 1: snap_data holds a value not yet accepted by the consumer.
REQ-013 The block SHALL have port snap_ovr, output, 1: sticky flag, set when a snapshot request was lost.

Function
REQ-014 The control FSM SHALL have two states, PRIME and RUN.
REQ-015 PRIME is entered on reset; in PRIME the block loads prev <= count_i, leaves acc_o unchanged, and moves to RUN on the next edge.
REQ-016 In RUN, on each cycle, delta = (count_i - prev) mod 2^SRC_W; the block then loads prev <= count_i.
REQ-017 In RUN, acc_o SHALL be updated to min(acc_o + delta, 2^ACC_W-1); the sum is computed at ACC_W+1 bits so it cannot wrap.
REQ-018 If acc_o + delta > 2^ACC_W-1, acc_o SHALL hold all-ones and sat_o SHALL be set on that same edge.
REQ-019 acc_o SHALL be updated with 1-cycle latency: a count_i change sampled at edge N is visible on acc_o after edge N.
REQ-020 When count_i wraps from 2^SRC_W-1 to 0, delta SHALL be 1, not negative.
REQ-021 Any step of up to 2^SRC_W-1 SHALL be counted exactly; a larger source advance between two samples is aliased, is out of scope, and SHALL NOT be detected.
REQ-022 When clr=1, on that edge the block SHALL set acc_o <= 0, sat_o <= 0 and prev <= count_i.
REQ-023 That cycle's delta SHALL be discarded; clr takes priority over accumulate and over saturation.
REQ-024 A snapshot SHALL be captured when snap_req=1 and either snap_valid=0 or snap_ready=1.
REQ-025 On capture, snap_data SHALL take the acc_o value present before that edge (pre-update, pre-clear), and snap_valid SHALL be 1 after the edge.
REQ-026 The snapshot handshake completes when snap_valid=1 and snap_ready=1 on the same edge.
REQ-027 If no new capture occurs on that edge, snap_valid SHALL go to 0.
REQ-028 If a new capture occurs on that edge, snap_valid SHALL stay 1 with the new snap_data, giving back-to-back throughput.
REQ-029 While snap_valid=1 and snap_ready=0, snap_data SHALL be held stable.
REQ-030 A snap_req in that condition SHALL be dropped, and snap_ovr SHALL be set.
REQ-031 snap_ovr SHALL be cleared only by rst; clr SHALL NOT clear it.
REQ-032 The snapshot path SHALL operate in both PRIME and RUN.

Reset
REQ-033 With rst=1 at an edge, the block SHALL reset: state=PRIME, acc_o=0, sat_o=0, snap_data=0, snap_valid=0, snap_ovr=0, prev=0.
REQ-034 rst SHALL override clr, snap_req and any in-flight handshake, and the pending snapshot SHALL be discarded.
REQ-035 After rst is released, the first count_i sample SHALL only prime prev, so no spurious delta is added.

Verification
REQ-036 Prime: release rst with count_i=2, hold 3 cycles -> acc_o=0.
REQ-037 Step and wrap: with count_i stepping 2,3,0,1 -> acc_o=3; then a jump 1->0 -> delta 3, acc_o=6.
REQ-038 Saturation: with ACC_W=4 and acc_o=14, a step of +3 -> acc_o=15 and sat_o=1.
REQ-039 Clear: clr with a simultaneous step of +2 -> acc_o=0 and sat_o=0; the next +1 step -> acc_o=1.
REQ-040 Snapshot and clear: with acc_o=9, snap_req and clr on the same cycle -> snap_data=9, snap_valid=1, acc_o=0.
REQ-041 Overflow: with snap_valid=1 and snap_ready=0, snap_req -> snap_data is unchanged and snap_ovr=1.
REQ-042 Back-to-back: snap_ready=1 with snap_req=1 -> snap_valid stays 1 and snap_data=new value.
REQ-043 Mid-operation reset: rst while snap_valid=1 -> all outputs are 0 on the next cycle, and the next count_i step is not counted.
